bsk_prm: RTL and testbench

BSK_PRM -- requirements
Module: bsk_prm

---
 rtl/bsk_prm.sv | 225 ++++++++++++++++++++++
 tb/tb_bsk_prm.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsk_prm.sv
// -----------------------------------------------------------------------------
// bsk_prm : relay command register block with host bus, refresh watchdog and
//           far-end line test detector.
//
// The host writes a 16-bit command word and an enable bit over an asynchronous
// strobe bus. The command word drives the relay outputs while the block signal
// allows it. The command is dropped if the host stops refreshing it. A
// separate detector checks that the far-end transmitter's test square wave is
// arriving at roughly the nominal clk/8 rate.
//
// Parameters
//   VERSION    : firmware version, read back in register 11 bits [7:1]
//   CS         : chip-select code that selects this block
//   CODE_BLOCK : block identity, read back in register 11 bits [15:8]
//   TIMEOUT    : command refresh timeout in clk cycles
//
// Ports
//   clk     : system clock, all state on its rising edge
//   iRes    : asynchronous active-low reset
//   bD      : 16-bit bidirectional host data bus
//   iA      : register address
//   iCS     : chip-select code, block selected when equal to CS
//   iRd     : read strobe, active-low, combinational read path
//   iWr     : write strobe, active-low, write taken on its rising edge
//   iBl     : block signal, 0 forces the relay outputs off
//   iTest   : line test square wave from the far-end transmitter
//   oCom    : relay command outputs, active-high, registered
//   oComInd : command indication, active-low copy of oCom, registered
//   oCS     : chip-selected flag, active-low, combinational
//
// Register map
//   00 R/W : command word
//   01 R   : current oCom
//   10 R/W : bit0 enable, other bits read 0
//   11 R   : {CODE_BLOCK, VERSION, testOk}
// -----------------------------------------------------------------------------
module bsk_prm #(
    parameter logic [6:0]  VERSION    = 7'h25,
    parameter logic [3:0]  CS         = 4'b1101,
    parameter logic [7:0]  CODE_BLOCK = 8'hA5,
    parameter logic [15:0] TIMEOUT    = 16'd2000
) (
    input  logic        clk,
    input  logic        iRes,
    inout  wire  [15:0] bD,
    input  logic [1:0]  iA,
    input  logic [3:0]  iCS,
    input  logic        iRd,
    input  logic        iWr,
    input  logic        iBl,
    input  logic        iTest,
    output logic [15:0] oCom,
    output logic [15:0] oComInd,
    output logic        oCS
);

    localparam logic [1:0] ADDR_CMD   = 2'b00;
    localparam logic [1:0] ADDR_OUT   = 2'b01;
    localparam logic [1:0] ADDR_EN    = 2'b10;
    localparam logic [1:0] ADDR_IDENT = 2'b11;

    // Acceptable number of test edges in one 64-clk window: the nominal
    // toggle-every-4-clk wave gives 16, with one edge of slack either way.
    localparam logic [5:0] EDGES_MIN = 6'd15;
    localparam logic [5:0] EDGES_MAX = 6'd17;
    localparam logic [5:0] WIN_LAST  = 6'd63;
    localparam logic [5:0] EDGES_SAT = 6'd63;

    // Host-side synchronizer chains. wrSync[2] is one stage past the
    // synchronized strobe and only exists to find its rising edge.
    logic [2:0]  wrSync;
    logic [1:0]  csSync;
    logic [1:0]  addrSync1;
    logic [1:0]  addrSync2;
    logic [15:0] dataSync1;
    logic [15:0] dataSync2;

    // Line test synchronizer, same structure as the write strobe.
    logic [2:0]  testSync;

    logic        csMatch;
    logic        wrRise;
    logic        wrValid;
    logic        wrCmd;
    logic        wrEn;
    logic        testEdge;

    logic [15:0] cmdReg;
    logic        en;
    logic [15:0] refresh;
    logic [15:0] comNext;

    logic [5:0]  winCnt;
    logic [5:0]  edgeCnt;
    logic        testOk;

    logic [15:0] rdData;

    // Chip select decode is purely combinational: it gates the read path and
    // the oCS flag directly, and feeds the write synchronizer.
    assign csMatch = (iCS == CS);
    assign oCS     = ~csMatch;

    // A write is the synchronized 0->1 of iWr, qualified by the synchronized
    // chip select. Address and data come from their own synchronizers, which
    // are settled because the host holds them well past the strobe.
    assign wrRise  = wrSync[1] & ~wrSync[2];
    assign wrValid = wrRise & csSync[1];
    assign wrCmd   = wrValid && (addrSync2 == ADDR_CMD);
    assign wrEn    = wrValid && (addrSync2 == ADDR_EN);

    assign testEdge = testSync[1] ^ testSync[2];

    // Bring the asynchronous host strobe, select, address and data into the
    // clk domain. The strobe chain resets to the idle-high level so that a
    // write interrupted by reset cannot complete afterwards: only a fresh
    // low-then-high strobe produces a rising edge.
    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            wrSync    <= 3'b111;
            csSync    <= 2'b00;
            addrSync1 <= 2'b00;
            addrSync2 <= 2'b00;
            dataSync1 <= 16'h0000;
            dataSync2 <= 16'h0000;
        end else begin
            wrSync    <= {wrSync[1:0], iWr};
            csSync    <= {csSync[0], csMatch};
            addrSync1 <= iA;
            addrSync2 <= addrSync1;
            dataSync1 <= bD;
            dataSync2 <= dataSync1;
        end
    end

    // Command word and refresh watchdog. Every command write reloads the
    // watchdog; if it runs down to zero the command is dropped. A write that
    // lands on the expiry clk takes priority so a just-in-time refresh keeps
    // the relays energised with the new data.
    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            cmdReg  <= 16'h0000;
            refresh <= 16'h0000;
        end else if (wrCmd) begin
            cmdReg  <= dataSync2;
            refresh <= TIMEOUT;
        end else if (refresh != 16'h0000) begin
            refresh <= refresh - 16'd1;
            if (refresh == 16'd1) begin
                cmdReg <= 16'h0000;
            end
        end
    end

    // Output enable bit, written through register 10.
    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            en <= 1'b0;
        end else if (wrEn) begin
            en <= dataSync2[0];
        end
    end

    // Relay outputs are registered so that the relay drivers see glitch-free
    // levels; the indication lines are the inverted copy.
    assign comNext = cmdReg & {16{en & iBl}};

    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            oCom    <= 16'h0000;
            oComInd <= 16'hFFFF;
        end else begin
            oCom    <= comNext;
            oComInd <= ~comNext;
        end
    end

    // Line test synchronizer. Resets low together with the detector counters.
    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            testSync <= 3'b000;
        end else begin
            testSync <= {testSync[1:0], iTest};
        end
    end

    // Test edge counter over a free-running 64-clk window. At the last clk of
    // each window the count is judged and restarted; an edge seen on that
    // same clk belongs to the new window, so the restart value is 1. The
    // counter saturates so a very fast or noisy line cannot wrap back into
    // the accepted range.
    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            winCnt  <= 6'd0;
            edgeCnt <= 6'd0;
            testOk  <= 1'b0;
        end else begin
            winCnt <= winCnt + 6'd1;
            if (winCnt == WIN_LAST) begin
                testOk  <= (edgeCnt >= EDGES_MIN) && (edgeCnt <= EDGES_MAX);
                edgeCnt <= {5'd0, testEdge};
            end else if (testEdge && (edgeCnt != EDGES_SAT)) begin
                edgeCnt <= edgeCnt + 6'd1;
            end
        end
    end

    // Read multiplexer. Works during reset as well, since every source is
    // either a reset-cleared flop or a constant.
    always_comb begin
        rdData = 16'h0000;
        case (iA)
            ADDR_CMD:   rdData = cmdReg;
            ADDR_OUT:   rdData = oCom;
            ADDR_EN:    rdData = {15'd0, en};
            ADDR_IDENT: rdData = {CODE_BLOCK, VERSION, testOk};
            default:    rdData = 16'h0000;
        endcase
    end

    // The block only drives the shared bus while it is both selected and
    // being read; otherwise it floats so other devices and the host can use it.
    assign bD = (!iRd && csMatch) ? rdData : 16'hzzzz;

endmodule

// File: tb/tb_bsk_prm.sv
// -----------------------------------------------------------------------------
// tb_bsk_prm : self-checking bench for bsk_prm, built with a short refresh
// timeout. Expected register and output values come from a small time-based
// model: the command word is valid for TIMEOUT clks from its update clk, the
// relay outputs show the previous clk's command gated by enable and block,
// and the test detector result follows from the number of edges placed in
// one window.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bsk_prm;

    localparam logic [3:0] CSCODE = 4'b1101;
    localparam int         TMO    = 10;

    logic        clk = 1'b0;
    logic        iRes;
    logic [1:0]  iA;
    logic [3:0]  iCS;
    logic        iRd;
    logic        iWr;
    logic        iBl;
    logic        iTest;
    logic [15:0] oCom;
    logic [15:0] oComInd;
    logic        oCS;
    logic        tbDrive;
    logic [15:0] tbData;
    wire  [15:0] bD;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int relCyc = 0;

    logic [15:0] mCmd;
    int          mCmdCyc;
    logic        mEn;

    assign bD = tbDrive ? tbData : 16'hzzzz;

    always #5 clk = ~clk;

    // Posedge counter used to time-stamp command updates and detector windows.
    always @(posedge clk) cyc <= cyc + 1;

    bsk_prm #(
        .VERSION   (7'h25),
        .CS        (CSCODE),
        .CODE_BLOCK(8'hA5),
        .TIMEOUT   (16'd10)
    ) dut (
        .clk    (clk),
        .iRes   (iRes),
        .bD     (bD),
        .iA     (iA),
        .iCS    (iCS),
        .iRd    (iRd),
        .iWr    (iWr),
        .iBl    (iBl),
        .iTest  (iTest),
        .oCom   (oCom),
        .oComInd(oComInd),
        .oCS    (oCS)
    );

    // Command word the DUT should hold after posedge number c.
    function automatic logic [15:0] expCmd(input int c);
        if (c >= mCmdCyc && (c - mCmdCyc) < TMO) return mCmd;
        return 16'h0000;
    endfunction

    // Relay outputs after posedge c, assuming enable and block were stable.
    function automatic logic [15:0] expCom(input int c);
        if (mEn && iBl) return expCmd(c - 1);
        return 16'h0000;
    endfunction

    task automatic modelReset();
        mCmd    = 16'h0000;
        mCmdCyc = -100000;
        mEn     = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [15:0] v);
        tbDrive = 1'b0;
        iA  = a;
        iCS = CSCODE;
        iRd = 1'b0;
        #0.2;
        v   = bD;
        iRd = 1'b1;
        iCS = 4'h0;
        #0.2;
    endtask

    task automatic writeReg(input logic [1:0] a, input logic [15:0] d, input bit csOk);
        int n;
        @(negedge clk);
        iA      = a;
        iCS     = csOk ? CSCODE : 4'b0110;
        tbData  = d;
        tbDrive = 1'b1;
        iRd     = 1'b1;
        iWr     = 1'b0;
        repeat (2) @(negedge clk);
        iWr = 1'b1;
        n   = cyc;
        repeat (4) @(negedge clk);
        tbDrive = 1'b0;
        iCS     = 4'h0;
        if (csOk && a == 2'b00) begin
            mCmd    = d;
            mCmdCyc = n + 3;
        end
        if (csOk && a == 2'b10) mEn = d[0];
    endtask

    task automatic test_reset();
        logic [15:0] v;
        iRes = 1'b0;
        repeat (2) @(negedge clk);
        if (oCom !== 16'h0000) begin errors++; $display("[TB] FAIL rst_oCom got %h expected %h", oCom, 16'h0000); end
        checks++;
        if (oComInd !== 16'hFFFF) begin errors++; $display("[TB] FAIL rst_oComInd got %h expected %h", oComInd, 16'hFFFF); end
        checks++;
        readReg(2'b00, v);
        if (v !== 16'h0000) begin errors++; $display("[TB] FAIL rst_reg00 got %h expected %h", v, 16'h0000); end
        checks++;
        readReg(2'b11, v);
        if (v !== 16'hA54A) begin errors++; $display("[TB] FAIL rst_reg11 got %h expected %h", v, 16'hA54A); end
        checks++;
        @(negedge clk);
        iRes   = 1'b1;
        relCyc = cyc;
        modelReset();
    endtask

    task automatic test_identity();
        @(negedge clk);
        iA = 2'b11; iCS = CSCODE; iRd = 1'b0; tbDrive = 1'b0;
        #0.2;
        if (bD !== 16'hA54A) begin errors++; $display("[TB] FAIL id_reg11 got %h expected %h", bD, 16'hA54A); end
        checks++;
        if (oCS !== 1'b0) begin errors++; $display("[TB] FAIL id_oCS_sel got %b expected %b", oCS, 1'b0); end
        checks++;
        iCS = 4'b1111; tbData = 16'h0000; tbDrive = 1'b1;
        #0.2;
        if (bD !== 16'h0000) begin errors++; $display("[TB] FAIL id_bus_float got %h expected %h", bD, 16'h0000); end
        checks++;
        if (oCS !== 1'b1) begin errors++; $display("[TB] FAIL id_oCS_unsel got %b expected %b", oCS, 1'b1); end
        checks++;
        iRd = 1'b1; tbDrive = 1'b0; iCS = 4'h0;
    endtask

    task automatic test_command();
        logic [15:0] v;
        iBl = 1'b1;
        writeReg(2'b10, 16'h0001, 1'b1);
        writeReg(2'b00, 16'h9231, 1'b1);
        if (oCom !== 16'h9231 || oCom !== expCom(cyc)) begin errors++; $display("[TB] FAIL cmd_oCom got %h expected %h", oCom, 16'h9231); end
        checks++;
        if (oComInd !== 16'h6DCE) begin errors++; $display("[TB] FAIL cmd_oComInd got %h expected %h", oComInd, 16'h6DCE); end
        checks++;
        readReg(2'b00, v);
        if (v !== 16'h9231) begin errors++; $display("[TB] FAIL cmd_reg00 got %h expected %h", v, 16'h9231); end
        checks++;
        readReg(2'b10, v);
        if (v !== 16'h0001) begin errors++; $display("[TB] FAIL cmd_reg10 got %h expected %h", v, 16'h0001); end
        checks++;
        iBl = 1'b0;
        @(negedge clk);
        if (oCom !== 16'h0000) begin errors++; $display("[TB] FAIL blk_oCom got %h expected %h", oCom, 16'h0000); end
        checks++;
        if (oComInd !== 16'hFFFF) begin errors++; $display("[TB] FAIL blk_oComInd got %h expected %h", oComInd, 16'hFFFF); end
        checks++;
        readReg(2'b00, v);
        if (v !== 16'h9231) begin errors++; $display("[TB] FAIL blk_reg00 got %h expected %h", v, 16'h9231); end
        checks++;
        iBl = 1'b1;
    endtask

    task automatic test_refresh();
        logic [15:0] e;
        iBl = 1'b1;
        writeReg(2'b00, 16'h00FF, 1'b1);
        for (int i = 0; i < 12; i++) begin
            e = expCom(cyc);
            if (oCom !== e) begin errors++; $display("[TB] FAIL timeout_step%0d got %h expected %h", i, oCom, e); end
            checks++;
            @(negedge clk);
        end
        writeReg(2'b00, 16'h00FF, 1'b1);
        repeat (2) @(negedge clk);
        writeReg(2'b00, 16'h00FF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            e = expCom(cyc);
            if (oCom !== 16'h00FF || oCom !== e) begin errors++; $display("[TB] FAIL rewrite_step%0d got %h expected %h", i, oCom, 16'h00FF); end
            checks++;
            @(negedge clk);
        end
        writeReg(2'b00, 16'h0F0F, 1'b1);
        repeat (3) @(negedge clk);
        writeReg(2'b00, 16'h1234, 1'b1);
        if (oCom !== 16'h1234) begin errors++; $display("[TB] FAIL expiry_tie got %h expected %h", oCom, 16'h1234); end
        checks++;
    endtask

    task automatic test_cs_mismatch();
        logic [15:0] v;
        writeReg(2'b00, 16'hABCD, 1'b1);
        writeReg(2'b00, 16'h1516, 1'b0);
        readReg(2'b00, v);
        if (v !== 16'hABCD || v !== expCmd(cyc)) begin errors++; $display("[TB] FAIL cs_mismatch_reg00 got %h expected %h", v, 16'hABCD); end
        checks++;
    endtask

    task automatic test_random_regs();
        logic [15:0] v;
        logic [15:0] e;
        logic [1:0]  a;
        logic [15:0] d;
        bit          ok;
        for (int i = 0; i < 16; i++) begin
            a   = 2'($urandom_range(3));
            d   = 16'($urandom);
            ok  = ($urandom_range(3) != 0);
            iBl = ($urandom_range(3) != 0);
            writeReg(a, d, ok);
            e = expCmd(cyc);
            readReg(2'b00, v);
            if (v !== e) begin errors++; $display("[TB] FAIL rand%0d_reg00 got %h expected %h", i, v, e); end
            checks++;
            e = expCom(cyc);
            readReg(2'b01, v);
            if (v !== e) begin errors++; $display("[TB] FAIL rand%0d_reg01 got %h expected %h", i, v, e); end
            checks++;
            if (oComInd !== ~e) begin errors++; $display("[TB] FAIL rand%0d_oComInd got %h expected %h", i, oComInd, ~e); end
            checks++;
            readReg(2'b10, v);
            if (v !== {15'd0, mEn}) begin errors++; $display("[TB] FAIL rand%0d_reg10 got %h expected %h", i, v, {15'd0, mEn}); end
            checks++;
            readReg(2'b11, v);
            if (v[15:1] !== 15'h52A5) begin errors++; $display("[TB] FAIL rand%0d_reg11 got %h expected %h", i, v[15:1], 15'h52A5); end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        iBl = 1'b1;
        writeReg(2'b10, 16'h0001, 1'b1);
        writeReg(2'b00, 16'hFFFF, 1'b1);
        if (oCom !== 16'hFFFF) begin errors++; $display("[TB] FAIL pre_reset_oCom got %h expected %h", oCom, 16'hFFFF); end
        checks++;
        iRes = 1'b0;
        #1;
        if (oCom !== 16'h0000) begin errors++; $display("[TB] FAIL async_rst_oCom got %h expected %h", oCom, 16'h0000); end
        checks++;
        if (oComInd !== 16'hFFFF) begin errors++; $display("[TB] FAIL async_rst_oComInd got %h expected %h", oComInd, 16'hFFFF); end
        checks++;
        @(negedge clk);
        iRes   = 1'b1;
        relCyc = cyc;
        modelReset();
        readReg(2'b10, v);
        if (v !== 16'h0000) begin errors++; $display("[TB] FAIL post_rst_reg10 got %h expected %h", v, 16'h0000); end
        checks++;
        // reset lands between the strobe rise and the register update
        @(negedge clk);
        iA = 2'b00; iCS = CSCODE; tbData = 16'h5A5A; tbDrive = 1'b1; iWr = 1'b0;
        repeat (2) @(negedge clk);
        iWr = 1'b1;
        @(negedge clk);
        iRes = 1'b0;
        @(negedge clk);
        iRes   = 1'b1;
        relCyc = cyc;
        modelReset();
        repeat (4) @(negedge clk);
        tbDrive = 1'b0; iCS = 4'h0;
        readReg(2'b00, v);
        if (v !== 16'h0000) begin errors++; $display("[TB] FAIL dropped_write_reg00 got %h expected %h", v, 16'h0000); end
        checks++;
        writeReg(2'b00, 16'h3C3C, 1'b1);
        readReg(2'b00, v);
        if (v !== 16'h3C3C) begin errors++; $display("[TB] FAIL fresh_write_reg00 got %h expected %h", v, 16'h3C3C); end
        checks++;
    endtask

    task automatic test_detect();
        logic [15:0] v;
        for (int i = 0; i < 140; i++) begin
            if (i % 4 == 0) iTest = ~iTest;
            @(negedge clk);
        end
        readReg(2'b11, v);
        if (v !== 16'hA54B) begin errors++; $display("[TB] FAIL detect_nominal got %h expected %h", v, 16'hA54B); end
        checks++;
        repeat (129) @(negedge clk);
        readReg(2'b11, v);
        if (v !== 16'hA54A) begin errors++; $display("[TB] FAIL detect_stuck got %h expected %h", v, 16'hA54A); end
        checks++;
        for (int i = 0; i < 140; i++) begin
            if (i % 2 == 0) iTest = ~iTest;
            @(negedge clk);
        end
        readReg(2'b11, v);
        if (v !== 16'hA54A) begin errors++; $display("[TB] FAIL detect_fast got %h expected %h", v, 16'hA54A); end
        checks++;
        repeat (4) @(negedge clk);
    endtask

    // Place exactly k edges inside one detector window, always including its
    // first clk, and compare the verdict against the 15..17 acceptance band.
    task automatic test_window_edges();
        int          ks [8];
        int          k;
        int          placed;
        int          pos;
        bit [63:0]   sel;
        logic [15:0] v;
        logic [15:0] e;
        ks = '{15, 17, 14, 18, 16, 0, 0, 0};
        for (int t = 5; t < 8; t++) ks[t] = $urandom_range(22, 10);
        for (int t = 0; t < 8; t++) begin
            k      = ks[t];
            sel    = '0;
            sel[0] = 1'b1;
            placed = 1;
            while (placed < k) begin
                pos = $urandom_range(63);
                if (!sel[pos]) begin
                    sel[pos] = 1'b1;
                    placed++;
                end
            end
            for (int j = 0; j < 64 && ((cyc + 3 - relCyc) % 64) != 0; j++) @(negedge clk);
            for (int i = 0; i < 64; i++) begin
                if (sel[i]) iTest = ~iTest;
                @(negedge clk);
            end
            repeat (3) @(negedge clk);
            e = {8'hA5, 7'h25, (k >= 15 && k <= 17)};
            readReg(2'b11, v);
            if (v !== e) begin errors++; $display("[TB] FAIL window_k%0d got %h expected %h", k, v, e); end
            checks++;
        end
    endtask

    initial begin
        iRes = 1'b0; iWr = 1'b1; iRd = 1'b1; iCS = 4'h0; iA = 2'b00;
        iBl = 1'b0; iTest = 1'b0; tbDrive = 1'b0; tbData = 16'h0000;
        modelReset();
        test_reset();
        test_identity();
        test_command();
        test_refresh();
        test_cs_mismatch();
        test_random_regs();
        test_reset_mid();
        test_detect();
        test_window_edges();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
